// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: takes bitstream words over valid/ready and shifts them MSB-first into a ccff chain.
// Optional feature macro CCFF_READBACK_EN adds rb_data, which captures the chain tail while shifting.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter int unsigned WORD_W    = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              error
`ifdef CCFF_READBACK_EN
    ,
    output logic [CHAIN_LEN-1:0] rb_data
`endif
);

    localparam int unsigned BitCntW  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WordCntW = $clog2(WORD_W + 1);
    localparam int unsigned StallW   = $clog2(TIMEOUT + 1);

    localparam logic [BitCntW-1:0]  LastBit   = BitCntW'(CHAIN_LEN);
    localparam logic [WordCntW-1:0] LastWord  = WordCntW'(WORD_W);
    localparam logic [StallW-1:0]   LastStall = StallW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StShift, StDone} state_e;

    state_e              r_state,     w_state_nxt;
    logic [WORD_W-1:0]   r_shift,     w_shift_nxt;
    logic [BitCntW-1:0]  r_bit_cnt,   w_bit_cnt_nxt;
    logic [WordCntW-1:0] r_word_cnt,  w_word_cnt_nxt;
    logic [StallW-1:0]   r_stall_cnt, w_stall_cnt_nxt;
    logic                r_head,      w_head_nxt;
    logic                r_error,     w_error_nxt;
    logic                r_aborted,   w_aborted_nxt;

    logic [WORD_W-1:0]   w_shift_sl;
    logic [BitCntW-1:0]  w_bit_inc;
    logic [WordCntW-1:0] w_word_inc;

    assign w_shift_sl = r_shift << 1;
    assign w_bit_inc  = r_bit_cnt + BitCntW'(1);
    assign w_word_inc = r_word_cnt + WordCntW'(1);

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
            r_head      <= 1'b0;
            r_error     <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_head      <= w_head_nxt;
            r_error     <= w_error_nxt;
            r_aborted   <= w_aborted_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_word_cnt_nxt  = r_word_cnt;
        w_stall_cnt_nxt = r_stall_cnt;
        w_head_nxt      = r_head;
        w_error_nxt     = r_error;
        w_aborted_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt     = StFetch;
                    w_bit_cnt_nxt   = '0;
                    w_stall_cnt_nxt = '0;
                    w_error_nxt     = 1'b0;
                end
            end
            StFetch: begin
                // Abort outranks both the handshake and the stall timeout.
                if (abort) begin
                    w_state_nxt   = StIdle;
                    w_aborted_nxt = 1'b1;
                end else if (word_valid) begin
                    w_state_nxt     = StShift;
                    w_shift_nxt     = word_data;
                    w_head_nxt      = word_data[WORD_W-1];
                    w_word_cnt_nxt  = '0;
                    w_stall_cnt_nxt = '0;
                end else if (r_stall_cnt == LastStall) begin
                    w_state_nxt = StIdle;
                    w_error_nxt = 1'b1;
                end else begin
                    w_stall_cnt_nxt = r_stall_cnt + StallW'(1);
                end
            end
            StShift: begin
                if (abort) begin
                    w_state_nxt   = StIdle;
                    w_aborted_nxt = 1'b1;
                end else begin
                    w_shift_nxt    = w_shift_sl;
                    w_head_nxt     = w_shift_sl[WORD_W-1];
                    w_word_cnt_nxt = w_word_inc;
                    w_bit_cnt_nxt  = w_bit_inc;
                    // Chain completion wins, so a partial last word drops its low bits.
                    if (w_bit_inc == LastBit) begin
                        w_state_nxt = StDone;
                    end else if (w_word_inc == LastWord) begin
                        w_state_nxt = StFetch;
                    end
                end
            end
            StDone: begin
                w_state_nxt   = StIdle;
                w_aborted_nxt = abort;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign word_ready = (r_state == StFetch);
    assign shift_en   = (r_state == StShift);
    assign busy       = (r_state != StIdle);
    assign done       = (r_state == StDone);
    assign ccff_head  = r_head;
    assign aborted    = r_aborted;
    assign error      = r_error;

`ifdef CCFF_READBACK_EN
    logic [CHAIN_LEN-1:0] r_rb;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_rb <= '0;
        end else if (r_state == StIdle && start) begin
            r_rb <= '0;
        end else if (r_state == StShift && !abort) begin
            r_rb <= (r_rb << 1) | CHAIN_LEN'(ccff_tail);
        end
    end

    assign rb_data = r_rb;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed self-checking bench for ccff_chain_loader: an 8-bit chain instance and a 6-bit chain
// instance, each driving a behavioural chain model.
module tb_ccff_chain_loader;

    logic       prog_clk   = 1'b0;
    logic       pReset     = 1'b1;
    logic       start8     = 1'b0;
    logic       start6     = 1'b0;
    logic       abort      = 1'b0;
    logic       word_valid = 1'b0;
    logic [3:0] word_data  = 4'h0;

    logic ready8, head8, sh8, busy8, done8, abrt8, err8;
    logic ready6, head6, sh6, busy6, done6, abrt6, err6;
`ifdef CCFF_READBACK_EN
    logic [7:0] rb8;
    logic [5:0] rb6;
`endif

    logic [7:0] chain8        = 8'h00;
    logic [5:0] chain6        = 6'h00;
    logic       chain_set     = 1'b0;
    logic [7:0] chain_set_val = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 prog_clk = ~prog_clk;

    // Behavioural fabric chains: advance on gated edges, head enters at bit 0, tail is the MSB.
    always @(posedge prog_clk) begin
        if (chain_set) chain8 <= chain_set_val;
        else if (sh8)  chain8 <= {chain8[6:0], head8};
        if (sh6) chain6 <= {chain6[4:0], head6};
    end

    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(4), .TIMEOUT(16)) dut8 (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .start      (start8),
        .abort      (abort),
        .word_valid (word_valid),
        .word_ready (ready8),
        .word_data  (word_data),
        .ccff_head  (head8),
        .ccff_tail  (chain8[7]),
        .shift_en   (sh8),
        .busy       (busy8),
        .done       (done8),
        .aborted    (abrt8),
        .error      (err8)
`ifdef CCFF_READBACK_EN
        ,
        .rb_data    (rb8)
`endif
    );

    ccff_chain_loader #(.CHAIN_LEN(6), .WORD_W(4), .TIMEOUT(16)) dut6 (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .start      (start6),
        .abort      (abort),
        .word_valid (word_valid),
        .word_ready (ready6),
        .word_data  (word_data),
        .ccff_head  (head6),
        .ccff_tail  (chain6[5]),
        .shift_en   (sh6),
        .busy       (busy6),
        .done       (done6),
        .aborted    (abrt6),
        .error      (err6)
`ifdef CCFF_READBACK_EN
        ,
        .rb_data    (rb6)
`endif
    );

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic test_reset();
        #2 pReset = 1'b0;
        #1;
        checks++;
        if ({ready8, head8, sh8, busy8, done8, abrt8, err8} !== 7'b0) begin
            errors++;
            $display("FAIL reset_async_dut8 got %b want 0000000",
                     {ready8, head8, sh8, busy8, done8, abrt8, err8});
        end
        checks++;
        if ({ready6, head6, sh6, busy6, done6, abrt6, err6} !== 7'b0) begin
            errors++;
            $display("FAIL reset_async_dut6 got %b want 0000000",
                     {ready6, head6, sh6, busy6, done6, abrt6, err6});
        end
        start8 = 1'b1;
        tick();
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_holds_idle got %b want 0", busy8);
        end
        start8 = 1'b0;
        pReset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] exp_sh;
        logic [7:0]  exp_bits;
        logic [7:0]  got_bits;
        int          nsh;
        exp_sh     = 32'h0000_07BC;  // shift_en in cycles 2-5 and 7-10
        exp_bits   = 8'hA5;
        got_bits   = 8'h00;
        nsh        = 0;
        word_valid = 1'b1;
        word_data  = 4'hA;
        start8     = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) start8 = 1'b0;
            if (c == 2) word_data = 4'h5;
            checks++;
            if (sh8 !== exp_sh[c]) begin
                errors++;
                $display("FAIL basic_shift_en cycle %0d got %b want %b", c, sh8, exp_sh[c]);
            end
            checks++;
            if (ready8 !== (c == 1 || c == 6)) begin
                errors++;
                $display("FAIL basic_word_ready cycle %0d got %b want %b", c, ready8,
                         (c == 1 || c == 6));
            end
            checks++;
            if (done8 !== (c == 11)) begin
                errors++;
                $display("FAIL basic_done cycle %0d got %b want %b", c, done8, (c == 11));
            end
            checks++;
            if (busy8 !== (c <= 11)) begin
                errors++;
                $display("FAIL basic_busy cycle %0d got %b want %b", c, busy8, (c <= 11));
            end
            if (sh8 === 1'b1) begin
                if (nsh < 8) got_bits[7-nsh] = head8;
                nsh++;
            end
        end
        checks++;
        if (got_bits !== exp_bits) begin
            errors++;
            $display("FAIL basic_head_bits got %h want %h", got_bits, exp_bits);
        end
        checks++;
        if (chain8 !== exp_bits) begin
            errors++;
            $display("FAIL basic_chain got %h want %h", chain8, exp_bits);
        end
    endtask

    task automatic test_partial_word();
        logic [5:0] got_bits;
        int         nsh;
        int         done_c;
        got_bits   = 6'h00;
        nsh        = 0;
        done_c     = -1;
        word_valid = 1'b1;
        word_data  = 4'hF;
        start6     = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) start6 = 1'b0;
            if (c == 2) word_data = 4'h8;
            if (c == 6) begin
                checks++;
                if (ready6 !== 1'b1) begin
                    errors++;
                    $display("FAIL partial_ready_second got %b want 1", ready6);
                end
            end
            if (sh6 === 1'b1) begin
                if (nsh < 6) got_bits[5-nsh] = head6;
                nsh++;
            end
            if (done6 === 1'b1) done_c = c;
        end
        checks++;
        if (nsh != 6) begin
            errors++;
            $display("FAIL partial_shift_count got %0d want 6", nsh);
        end
        checks++;
        if (got_bits !== 6'b111110) begin
            errors++;
            $display("FAIL partial_head_bits got %b want 111110", got_bits);
        end
        checks++;
        if (done_c != 9) begin
            errors++;
            $display("FAIL partial_done_cycle got %0d want 9", done_c);
        end
        checks++;
        if (chain6 !== 6'h3E || busy6 !== 1'b0) begin
            errors++;
            $display("FAIL partial_chain_idle got chain=%h busy=%b want chain=3e busy=0",
                     chain6, busy6);
        end
    endtask

    task automatic test_stall();
        logic [7:0] got_bits;
        int         nsh;
        int         done_c;
        got_bits   = 8'h00;
        nsh        = 0;
        done_c     = -1;
        word_valid = 1'b1;
        word_data  = 4'hA;
        start8     = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) start8 = 1'b0;
            if (c == 2) word_data = 4'h5;
            if (c == 5) word_valid = 1'b0;
            if (c >= 6 && c <= 8) begin
                checks++;
                if ({sh8, ready8, err8} !== 3'b010) begin
                    errors++;
                    $display("FAIL stall_fetch cycle %0d got sh/rdy/err=%b want 010", c,
                             {sh8, ready8, err8});
                end
            end
            if (c == 9) word_valid = 1'b1;
            if (sh8 === 1'b1) begin
                if (nsh < 8) got_bits[7-nsh] = head8;
                nsh++;
            end
            if (done8 === 1'b1) done_c = c;
        end
        checks++;
        if (nsh != 8 || got_bits !== 8'hA5) begin
            errors++;
            $display("FAIL stall_bits got n=%0d bits=%h want n=8 bits=a5", nsh, got_bits);
        end
        checks++;
        if (done_c != 14 || err8 !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got cycle=%0d err=%b want cycle=14 err=0", done_c, err8);
        end
    endtask

    task automatic test_timeout();
        word_valid = 1'b1;
        word_data  = 4'hA;
        start8     = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (c == 1) start8 = 1'b0;
            if (c == 2) word_valid = 1'b0;
            if (c == 21) begin
                checks++;
                if ({busy8, err8} !== 2'b10) begin
                    errors++;
                    $display("FAIL timeout_last_fetch got busy/err=%b want 10", {busy8, err8});
                end
            end
            if (c == 22) begin
                checks++;
                if ({busy8, err8, ready8} !== 3'b010) begin
                    errors++;
                    $display("FAIL timeout_error got busy/err/rdy=%b want 010",
                             {busy8, err8, ready8});
                end
            end
        end
        tick();
        checks++;
        if (err8 !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got %b want 1", err8);
        end
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        checks++;
        if ({busy8, err8} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_start_clears got busy/err=%b want 10", {busy8, err8});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy8, abrt8} !== 2'b01) begin
            errors++;
            $display("FAIL abort_in_fetch got busy/aborted=%b want 01", {busy8, abrt8});
        end
        tick();
    endtask

    task automatic test_abort();
        logic [1:0] got_bits;
        int         nsh;
        got_bits   = 2'b00;
        nsh        = 0;
        word_valid = 1'b1;
        word_data  = 4'hA;
        start8     = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) start8 = 1'b0;
            if (sh8 === 1'b1) begin
                if (nsh < 2) got_bits[1-nsh] = head8;
                nsh++;
            end
            if (c == 3) abort = 1'b1;
            if (c == 4) begin
                abort = 1'b0;
                checks++;
                if ({sh8, abrt8, busy8} !== 3'b010) begin
                    errors++;
                    $display("FAIL abort_pulse got sh/aborted/busy=%b want 010",
                             {sh8, abrt8, busy8});
                end
            end
            if (c == 5) begin
                checks++;
                if (abrt8 !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_single_pulse got %b want 0", abrt8);
                end
            end
        end
        checks++;
        if (nsh != 2 || got_bits !== 2'b10) begin
            errors++;
            $display("FAIL abort_shift_count got n=%0d bits=%b want n=2 bits=10", nsh, got_bits);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({abrt8, busy8} !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle_ignored got aborted/busy=%b want 00", {abrt8, busy8});
        end
    endtask

    task automatic test_reset_mid_shift();
        word_valid = 1'b1;
        word_data  = 4'hA;
        start8     = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        checks++;
        if ({sh8, head8} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_pre got sh/head=%b want 11", {sh8, head8});
        end
        #2 pReset = 1'b0;
        #1;
        checks++;
        if ({ready8, head8, sh8, busy8, done8, abrt8, err8} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs got %b want 0000000",
                     {ready8, head8, sh8, busy8, done8, abrt8, err8});
        end
        #2 pReset = 1'b1;
        tick();
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got %b want 0", busy8);
        end
    endtask

`ifdef CCFF_READBACK_EN
    task automatic test_readback();
        chain_set_val = 8'hC3;
        chain_set     = 1'b1;
        tick();
        chain_set  = 1'b0;
        word_valid = 1'b1;
        word_data  = 4'h5;
        start8     = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                start8 = 1'b0;
                checks++;
                if (rb8 !== 8'h00) begin
                    errors++;
                    $display("FAIL readback_clear got %h want 00", rb8);
                end
            end
            if (c == 2) word_data = 4'hA;
        end
        checks++;
        if (rb8 !== 8'hC3) begin
            errors++;
            $display("FAIL readback_data got %h want c3", rb8);
        end
        checks++;
        if (chain8 !== 8'h5A) begin
            errors++;
            $display("FAIL readback_chain got %h want 5a", chain8);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_partial_word();
        test_stall();
        test_timeout();
        test_abort();
        test_reset_mid_shift();
`ifdef CCFF_READBACK_EN
        test_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Bitstream sequencer for the configuration-flip-flop (ccff) chain that threads through the grid tiles, for example the chain through the I/O tiles.
- Accepts configuration words over a valid/ready stream and serializes them MSB-first onto ccff_head.
- Drives a shift enable that gates prog_clk to the fabric chain.
- Counts exactly CHAIN_LEN shifts, then signals done; stream stalls, abort and stall timeout are handled explicitly.

Parameters:
- CHAIN_LEN, 8: total ccff bits in the target chain (≥1).
- WORD_W, 4: width of one bitstream word (≥1).
- TIMEOUT, 16: maximum consecutive FETCH cycles without a handshake before error (≥1).

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- pReset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled in IDLE only.
- abort  in  1  cancel an in-progress load.
- word_valid  in  1  word_data is valid.
- word_ready  out  1  loader accepts word_data this cycle.
- word_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- ccff_head  out  1  serial data into the chain head (registered).
- ccff_tail  in  1  serial data from the chain tail.
- shift_en  out  1  chain advances on this prog_clk edge (clock-gate enable for the fabric).
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse: CHAIN_LEN bits shifted.
- aborted  out  1  one-cycle pulse: load cancelled by abort.
- error  out  1  sticky stall-timeout flag; cleared by the next accepted start.

Behaviour:
- Reset (pReset=0, async): state=IDLE, shift register=0, bit_cnt=0, stall_cnt=0.
  - All outputs 0: word_ready, ccff_head, shift_en, busy, done, aborted, error.
  - Takes effect immediately, including mid-SHIFT. No partial word is retained.
- Counter widths: bit_cnt is clog2(CHAIN_LEN+1) bits; word_cnt is clog2(WORD_W+1) bits; stall_cnt is clog2(TIMEOUT+1) bits.
- States: IDLE, FETCH, SHIFT, DONE. Outputs are decoded from registered state.
- IDLE:
  - start=1 → FETCH; bit_cnt=0, stall_cnt=0, error cleared.
  - start while busy is ignored.
- FETCH:
  - word_ready=1, shift_en=0; ccff_head holds its last value.
  - On handshake (word_valid & word_ready): load shift register, word_cnt=0, stall_cnt=0 → SHIFT.
  - Without handshake, stall_cnt increments. At stall_cnt==TIMEOUT-1 without handshake: error=1 → IDLE.
- SHIFT:
  - shift_en=1; ccff_head = shift-register MSB (set on the FETCH→SHIFT edge and on each shift edge).
  - Each cycle: shift left by 1, word_cnt++, bit_cnt++.
  - Exit to DONE if bit_cnt reaches CHAIN_LEN (this check has priority). Otherwise, after WORD_W shifts → FETCH.
  - word_ready=0 throughout.
- Final partial word: only the upper (CHAIN_LEN mod WORD_W) bits are shifted; remaining low bits are discarded.
- DONE: done=1 for exactly one cycle, shift_en=0 → IDLE.
- abort=1 in FETCH/SHIFT/DONE:
  - Next state IDLE; aborted=1 for one cycle.
  - shift_en deasserts on the same edge.
  - abort has priority over handshake, timeout and completion. abort in IDLE is ignored.
- Throughput with word_valid held high: WORD_W+1 cycles per full word (one FETCH bubble, shift_en low in the bubble).
- word_data is sampled only on a handshake; changes while word_ready=0 are ignored.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- Defined:
  - Adds output rb_data[CHAIN_LEN-1:0].
  - On every edge with shift_en=1, rb_data = {rb_data[CHAIN_LEN-2:0], ccff_tail}.
  - After done, rb_data holds the previous chain contents in original load order; the first bit out lands in rb_data[CHAIN_LEN-1].
  - rb_data is cleared at start acceptance and on reset, and frozen on abort.
- Undefined: the port and its logic are absent; ccff_tail is unused.

Test Plan:
- CHAIN_LEN=8, WORD_W=4, start at cycle 0, word_valid=1, words 0xA then 0x5.
  - Handshakes at cycles 1 and 6; shift_en high in cycles 2-5 and 7-10.
  - ccff_head on shift cycles = 1,0,1,0,0,1,0,1; done pulses in cycle 11; busy falls in cycle 12.
- CHAIN_LEN=6, WORD_W=4, words 0xF, 0x8.
  - Exactly 6 shift_en cycles, bits 1,1,1,1,1,0; second word's low 2 bits ignored; done after the 6th shift.
- Stall: word_valid low 3 cycles before the second word (TIMEOUT=16).
  - shift_en=0 and ccff_head held during the stall; error stays 0; total shifts still 8.
- Timeout: word_valid held low after the first word.
  - error=1 and busy=0 after 16 FETCH cycles; the next start clears error.
- abort after the 2nd shift of word 0xA: aborted pulses once, shift_en=0 on the next cycle, exactly 2 shifts total.
  - pReset low mid-SHIFT on a second run: all outputs 0 immediately, without waiting for a clock.
- CCFF_READBACK_EN: chain pre-loaded with 0xC3, then load 0x5A.
  - rb_data=0xC3 at done; chain now holds 0x5A.
